// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared shift-op codes and shifter state encoding
package mips_pkg;

   // Shift operation codes as carried down the EX stage
   localparam logic [1:0] SHOP_SLL = 2'b00;
   localparam logic [1:0] SHOP_SRL = 2'b01;
   localparam logic [1:0] SHOP_SRA = 2'b10;
   localparam logic [1:0] SHOP_RSV = 2'b11;

   // Iterative shifter control states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sh_state_t;

   // Only power-of-two step sizes up to half a word keep k within a narrow mux
   function automatic bit step_is_legal(input int step);
      return (step == 1) || (step == 2) || (step == 4) || (step == 8) || (step == 16);
   endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-step shift by k bits (k <= STEP)
module shift_step
   import mips_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int KW    = 1
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [1:0]       op,
   input  logic [KW-1:0]    k,
   output logic [WIDTH-1:0] shifted
);

   // Select the shift flavour; reserved op passes the operand through untouched
   always_comb begin
      shifted = acc;
      case (op)
         SHOP_SLL: shifted = acc << k;
         SHOP_SRL: shifted = acc >> k;
         SHOP_SRA: shifted = $unsigned($signed(acc) >>> k);
         default:  shifted = acc;
      endcase
   end

endmodule

// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle SLL/SRL/SRA unit with start/busy/done handshake
module iter_shifter
   import mips_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int STEP    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] shamt_in,
   input  logic [WIDTH-1:0] data_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   // Width of the per-cycle shift amount: just enough to encode 0..STEP
   localparam int KW = $clog2(STEP + 1);
   localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

   if (!step_is_legal(STEP)) begin : g_bad_step
      $error("iter_shifter: STEP must be one of 1, 2, 4, 8, 16");
   end

   if ((1 << SHAMT_W) != WIDTH) begin : g_bad_shamt_w
      $error("iter_shifter: SHAMT_W must equal log2(WIDTH)");
   end

   sh_state_t          state;
   logic [WIDTH-1:0]   acc;
   logic [SHAMT_W-1:0] rem;
   logic [1:0]         op_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   result_q;

   logic [SHAMT_W-1:0] shamt_lo;
   logic               accept;
   logic               finish_now;
   logic [SHAMT_W-1:0] k_full;
   logic [KW-1:0]      k;
   logic [SHAMT_W-1:0] rem_nxt;
   logic [WIDTH-1:0]   acc_nxt;

   // The amount arrives zero-extended to a full word; only the low bits matter
   logic unused_shamt_hi;
   assign unused_shamt_hi = ^shamt_in[WIDTH-1:SHAMT_W];

   assign shamt_lo = shamt_in[SHAMT_W-1:0];

   // A request is taken whenever we are not in the middle of shifting
   assign accept = start && !busy_q;

   // Zero amount and the reserved op both complete without any shift cycles
   assign finish_now = (shamt_lo == '0) || (op == SHOP_RSV);

   // Per-cycle amount is the smaller of STEP and what is still left to shift
   always_comb begin
      k_full  = (rem > STEP_AMT) ? STEP_AMT : rem;
      k       = KW'(k_full);
      rem_nxt = rem - k_full;
   end

   shift_step #(
      .WIDTH (WIDTH),
      .KW    (KW)
   ) u_shift_step (
      .acc     (acc),
      .op      (op_q),
      .k       (k),
      .shifted (acc_nxt)
   );

   // Control FSM plus the operand, remainder, op and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         acc      <= '0;
         rem      <= '0;
         op_q     <= SHOP_SLL;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            SHIFT: begin
               acc <= acc_nxt;
               rem <= rem_nxt;
               if (rem_nxt == '0) begin
                  state    <= DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  result_q <= acc_nxt;
               end
            end
            IDLE, DONE: begin
               if (accept) begin
                  acc  <= data_in;
                  rem  <= shamt_lo;
                  op_q <= op;
                  if (finish_now) begin
                     state    <= DONE;
                     done_q   <= 1'b1;
                     result_q <= data_in;
                  end else begin
                     state  <= SHIFT;
                     busy_q <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_iter_shifter.sv
// tb/tb_iter_shifter.sv - directed self-checking bench for iter_shifter (STEP=1 and STEP=4)
module tb_iter_shifter;

   logic        clk;
   logic        rst;
   logic        start1;
   logic        start4;
   logic [1:0]  op;
   logic [31:0] shamt;
   logic [31:0] data;
   logic        sel4;

   logic        busy1, done1, busy4, done4;
   logic [31:0] res1, res4;
   logic        busy_s, done_s;
   logic [31:0] res_s;

   int total;
   int bad;

   iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_dut1 (
      .clk      (clk),
      .rst      (rst),
      .start    (start1),
      .op       (op),
      .shamt_in (shamt),
      .data_in  (data),
      .busy     (busy1),
      .done     (done1),
      .result   (res1)
   );

   iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_dut4 (
      .clk      (clk),
      .rst      (rst),
      .start    (start4),
      .op       (op),
      .shamt_in (shamt),
      .data_in  (data),
      .busy     (busy4),
      .done     (done4),
      .result   (res4)
   );

   assign busy_s = sel4 ? busy4 : busy1;
   assign done_s = sel4 ? done4 : done1;
   assign res_s  = sel4 ? res4  : res1;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request to the selected DUT and step past the accepting edge
   task automatic launch(input bit s4, input logic [1:0] o, input logic [31:0] d, input logic [31:0] sa);
      sel4  = s4;
      op    = o;
      data  = d;
      shamt = sa;
      if (s4) start4 = 1'b1;
      else    start1 = 1'b1;
      tick();
      start1 = 1'b0;
      start4 = 1'b0;
   endtask

   // Count cycles (1 = first cycle after accept) until done, bounded
   task automatic wait_done(input int first, output int lat, output int nbusy);
      lat   = first;
      nbusy = 0;
      while (!done_s && lat <= 80) begin
         if (busy_s) nbusy++;
         tick();
         lat++;
      end
   endtask

   task automatic run(input string tag, input bit s4, input logic [1:0] o, input logic [31:0] d,
                      input logic [31:0] sa, input logic [31:0] exp_res, input int exp_lat, input int exp_busy);
      int lat, nb;
      launch(s4, o, d, sa);
      wait_done(1, lat, nb);
      chk({tag, "_lat"},  32'(lat), 32'(exp_lat));
      chk({tag, "_busy"}, 32'(nb),  32'(exp_busy));
      chk({tag, "_res"},  res_s,    exp_res);
   endtask

   initial begin
      int lat, nb, ndone;
      total  = 0;
      bad    = 0;
      clk    = 1'b0;
      rst    = 1'b1;
      start1 = 1'b1;
      start4 = 1'b1;
      op     = 2'b00;
      data   = 32'h0000_1234;
      shamt  = 32'h0000_0005;
      sel4   = 1'b0;

      // reset held two cycles with start asserted
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("rst_busy1", {31'd0, busy1}, 32'd0);
         chk("rst_done1", {31'd0, done1}, 32'd0);
         chk("rst_res1",  res1, 32'd0);
         chk("rst_busy4", {31'd0, busy4}, 32'd0);
         chk("rst_done4", {31'd0, done4}, 32'd0);
         chk("rst_res4",  res4, 32'd0);
      end
      rst    = 1'b0;
      start1 = 1'b0;
      start4 = 1'b0;
      tick();
      chk("post_rst_busy1", {31'd0, busy1}, 32'd0);
      chk("post_rst_done1", {31'd0, done1}, 32'd0);

      // main function, both step sizes
      run("sll5_s1",   1'b0, 2'b00, 32'h0000_0001, 32'h0000_0005, 32'h0000_0020, 6, 5);
      run("sra31_s1",  1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 31);
      run("srl7_s4",   1'b1, 2'b01, 32'hF000_000F, 32'h0000_0007, 32'h01E0_0000, 3, 2);
      run("sra9_s4",   1'b1, 2'b10, 32'h8000_0010, 32'h0000_0009, 32'hFFC0_0000, 4, 3);
      run("sll31_s4",  1'b1, 2'b00, 32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 9, 8);
      run("zero_s1",   1'b0, 2'b10, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1, 0);
      run("hi_only",   1'b0, 2'b01, 32'h8000_0000, 32'h0000_0020, 32'h8000_0000, 1, 0);
      run("rsv_s1",    1'b0, 2'b11, 32'h1234_5678, 32'h0000_000D, 32'h1234_5678, 1, 0);
      run("rsv_s4",    1'b1, 2'b11, 32'hCAFE_F00D, 32'h0000_001F, 32'hCAFE_F00D, 1, 0);

      // start while busy is dropped and inputs changed mid-op have no effect
      launch(1'b0, 2'b00, 32'h0000_0001, 32'h0000_0003);
      start1 = 1'b1;
      op     = 2'b01;
      data   = 32'h0000_FFFF;
      shamt  = 32'h0000_0001;
      tick();
      start1 = 1'b0;
      wait_done(2, lat, nb);
      chk("ign_lat",  32'(lat), 32'd4);
      chk("ign_busy", 32'(nb),  32'd2);
      chk("ign_res",  res1,     32'h0000_0008);
      tick();
      chk("ign_after_done", {31'd0, done1}, 32'd0);
      chk("ign_after_busy", {31'd0, busy1}, 32'd0);
      chk("ign_hold_res",   res1, 32'h0000_0008);

      // back-to-back start accepted in the DONE cycle
      launch(1'b0, 2'b00, 32'h0000_0001, 32'h0000_0002);
      wait_done(1, lat, nb);
      chk("b2b_lat1", 32'(lat), 32'd3);
      chk("b2b_res1", res1,     32'h0000_0004);
      launch(1'b0, 2'b01, 32'h0000_0100, 32'h0000_0004);
      chk("b2b_busy2",     {31'd0, busy1}, 32'd1);
      chk("b2b_hold_res",  res1, 32'h0000_0004);
      wait_done(1, lat, nb);
      chk("b2b_lat2", 32'(lat), 32'd5);
      chk("b2b_res2", res1,     32'h0000_0010);

      // reset in the middle of a shift aborts with no done
      launch(1'b0, 2'b00, 32'h0000_0001, 32'h0000_000A);
      tick();
      tick();
      chk("abort_pre_busy", {31'd0, busy1}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", {31'd0, busy1}, 32'd0);
      chk("abort_done", {31'd0, done1}, 32'd0);
      chk("abort_res",  res1, 32'd0);
      ndone = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (done1 || busy1) ndone++;
      end
      chk("abort_no_done", 32'(ndone), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
